bias_act_stage: RTL and testbench

- Post-accumulation output stage of the conv layer.
- Accepts one signed accumulator result per output channel from the MAC array via a valid/ready handshake.
- Fetches that channel's bias from the local bias memory through its read port, then adds, rescales, optionally applies ReLU and saturates to 16-bit.
- Emits the result through a 2-stage valid/ready pipeline to the output writeback.

---
 rtl/bias_act_stage.sv | 117 +++++++++++
 tb/tb_bias_act_stage.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bias_act_stage.sv
// Output stage of the conv layer: adds the per-channel bias to a rescaled accumulator,
// optionally applies ReLU, saturates to 16 bits and emits through a 2-stage pipeline.
module bias_act_stage #(
  parameter int CH_NUM = 10,
  parameter int ACC_W  = 32,
  parameter int SHIFT  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ACC_W-1:0] in_acc,
  input  logic [15:0]      in_ch,
  input  logic             in_last,
  input  logic             relu_en,
  output logic             read_bias_signal,
  output logic [15:0]      read_bias_addr,
  input  logic [15:0]      read_bias_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic [15:0]      out_ch,
  output logic             out_last,
  output logic             err_ch,
  output logic [15:0]      sat_cnt
);

  localparam int SW = ACC_W + 1;
  localparam logic [15:0]          CH_LIMIT = 16'(CH_NUM);
  localparam logic signed [SW-1:0] POS_MAX  = SW'(32767);
  localparam logic signed [SW-1:0] NEG_MIN  = ~POS_MAX;

  // Handshake: a transfer happens on a rising edge where valid && ready; valid, once
  // raised, holds its payload until that edge. in_ready looks through stage 2 at out_ready.
  logic                 s1_valid;
  logic signed [SW-1:0] s1_sum;
  logic [15:0]          s1_ch;
  logic                 s1_last;
  logic                 s1_relu;

  logic                 adv1, adv2, ch_ok;
  logic signed [SW-1:0] acc_ext, acc_sh, bias_ext, sum;
  logic signed [SW-1:0] relu_val;
  logic                 sat;
  logic [15:0]          clamped;

  always_comb begin
    adv2             = s1_valid && (!out_valid || out_ready);
    in_ready         = !s1_valid || adv2;
    adv1             = in_valid && in_ready;
    ch_ok            = in_ch < CH_LIMIT;
    read_bias_signal = adv1 && ch_ok;
    read_bias_addr   = read_bias_signal ? in_ch : 16'h0000;
    acc_ext          = {in_acc[ACC_W-1], in_acc};
    acc_sh           = acc_ext >>> SHIFT;
    bias_ext         = ch_ok ? {{(SW-16){read_bias_data[15]}}, read_bias_data} : '0;
    sum              = acc_sh + bias_ext;
  end

  always_comb begin
    relu_val = (s1_relu && s1_sum[SW-1]) ? '0 : s1_sum;
    sat      = 1'b0;
    clamped  = relu_val[15:0];
    if (relu_val > POS_MAX) begin
      sat     = 1'b1;
      clamped = 16'h7FFF;
    end else if (relu_val < NEG_MIN) begin
      sat     = 1'b1;
      clamped = 16'h8000;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      s1_ch    <= '0;
      s1_last  <= 1'b0;
      s1_relu  <= 1'b0;
    end else if (adv1) begin
      s1_valid <= 1'b1;
      s1_sum   <= sum;
      s1_ch    <= in_ch;
      s1_last  <= in_last;
      s1_relu  <= relu_en;
    end else if (adv2) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      out_last  <= 1'b0;
    end else if (adv2) begin
      out_valid <= 1'b1;
      out_data  <= clamped;
      out_ch    <= s1_ch;
      out_last  <= s1_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_ch  <= 1'b0;
      sat_cnt <= '0;
    end else begin
      if (adv1 && !ch_ok) err_ch <= 1'b1;
      if (adv2 && sat && sat_cnt != 16'hFFFF) sat_cnt <= sat_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_bias_act_stage.sv
// Bench for bias_act_stage: randomized traffic against an arithmetic reference model,
// with an expected-result queue checked at every output handshake.
module tb_bias_act_stage;

  localparam int CH_NUM = 10;

  logic        clk, rst;
  logic        in_valid, in_ready, in_last, relu_en;
  logic [31:0] in_acc;
  logic [15:0] in_ch;
  logic        read_bias_signal;
  logic [15:0] read_bias_addr, read_bias_data;
  logic        out_valid, out_ready, out_last, err_ch;
  logic [15:0] out_data, out_ch, sat_cnt;

  logic [15:0] bias_mem [16];
  logic [32:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          rdy_mode = 0;
  logic [15:0] sat_exp = 0;
  logic        err_exp = 0;

  bias_act_stage #(.CH_NUM(CH_NUM), .ACC_W(32), .SHIFT(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_acc(in_acc), .in_ch(in_ch),
    .in_last(in_last), .relu_en(relu_en),
    .read_bias_signal(read_bias_signal), .read_bias_addr(read_bias_addr),
    .read_bias_data(read_bias_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ch(out_ch), .out_last(out_last), .err_ch(err_ch), .sat_cnt(sat_cnt)
  );

  // clock / bias memory
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always_comb read_bias_data = (read_bias_addr < 16'd10) ? bias_mem[read_bias_addr[3:0]] : 16'h0000;

  // out_ready driver: 0 always ready, 1 pattern 1,0,0, 2 random, 3 stalled
  initial begin
    int phase;
    phase = 0;
    out_ready = 1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: out_ready = 1;
        1: begin out_ready = (phase % 3 == 0); phase++; end
        2: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 0;
      endcase
    end
  end

  // reference model: floor(acc / 256) + bias, ReLU, clamp; returns {saturated, value}
  function automatic logic [16:0] model(input logic [31:0] acc, input logic [15:0] ch,
                                        input logic relu, input logic [15:0] b);
    longint a, s;
    logic   st;
    a = longint'($signed(acc));
    if (a >= 0) s = a / 256;
    else        s = -((-a + 255) / 256);
    if (ch < CH_NUM) s = s + longint'($signed(b));
    if (relu && s < 0) s = 0;
    st = 0;
    if (s > 32767)       begin s = 32767;  st = 1; end
    else if (s < -32768) begin s = -32768; st = 1; end
    return {st, s[15:0]};
  endfunction

  // scoreboard: every output handshake pops the oldest accepted input; stalls must hold
  initial begin
    logic        stall_prev;
    logic [32:0] held, e;
    stall_prev = 0;
    held = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        stall_prev = 0;
      end else begin
        if (stall_prev) begin
          checks++;
          if (!(out_valid === 1'b1 && {out_last, out_ch, out_data} === held)) begin
            errors++;
            $display("FAIL stall_hold got v=%b %h required v=1 %h", out_valid,
                     {out_last, out_ch, out_data}, held);
          end
        end
        if (out_valid && out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output got %h required none", {out_last, out_ch, out_data});
          end else begin
            e = exp_q.pop_front();
            if ({out_last, out_ch, out_data} !== e) begin
              errors++;
              $display("FAIL output got last=%b ch=%0d data=%h required last=%b ch=%0d data=%h",
                       out_last, out_ch, out_data, e[32], e[31:16], e[15:0]);
            end
          end
        end
        stall_prev = out_valid && !out_ready;
        held = {out_last, out_ch, out_data};
      end
    end
  end

  // driver: hold one input until accepted, checking the bias read in the accept cycle
  task automatic send(input logic [31:0] acc, input logic [15:0] ch, input logic last,
                      input logic relu);
    logic [16:0] m;
    bit          done;
    int          budget;
    in_valid = 1; in_acc = acc; in_ch = ch; in_last = last; relu_en = relu;
    done = 0;
    budget = 0;
    while (!done && budget < 200) begin
      @(negedge clk);
      if (in_ready) begin
        done = 1;
        checks++;
        if (read_bias_signal !== (ch < CH_NUM) ||
            read_bias_addr !== ((ch < CH_NUM) ? ch : 16'h0000)) begin
          errors++;
          $display("FAIL bias_read ch=%0d got sig=%b addr=%0d", ch, read_bias_signal, read_bias_addr);
        end
        m = model(acc, ch, relu, bias_mem[ch[3:0]]);
        exp_q.push_back({last, ch, m[15:0]});
        if (m[16] && sat_exp != 16'hFFFF) sat_exp++;
        if (ch >= CH_NUM) err_exp = 1;
      end
      @(posedge clk);
      #1;
      budget++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL accept_timeout ch=%0d got in_ready=0 required 1", ch);
    end
    in_valid = 0;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 500) begin
      @(negedge clk);
      budget++;
    end
    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending required 0", exp_q.size());
    end
  endtask

  task automatic check16(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h required %h", name, got, want);
    end
  endtask

  task automatic test_reset();
    rst = 0; in_valid = 0; in_acc = 0; in_ch = 0; in_last = 0; relu_en = 0;
    for (int i = 0; i < 16; i++) bias_mem[i] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check16("reset_out_valid", {15'd0, out_valid}, 16'd0);
    @(posedge clk);
    #1;
    rst = 1;
    @(negedge clk);
    check16("reset_in_ready", {15'd0, in_ready}, 16'd1);
    check16("reset_out_data", out_data, 16'd0);
    check16("reset_out_ch", out_ch, 16'd0);
    check16("reset_out_last", {15'd0, out_last}, 16'd0);
    check16("reset_err_ch", {15'd0, err_ch}, 16'd0);
    check16("reset_sat_cnt", sat_cnt, 16'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    bias_mem[3] = 16'd5;
    send(32'h0000_1234, 16'd3, 1'b0, 1'b0);
    @(negedge clk);
    check16("latency_not_early", {15'd0, out_valid}, 16'd0);
    @(negedge clk);
    check16("latency_valid", {15'd0, out_valid}, 16'd1);
    check16("basic_data", out_data, 16'h0017);
    check16("basic_ch", out_ch, 16'd3);
    drain();
  endtask

  task automatic test_saturation();
    bias_mem[0] = 16'h7FFF;
    send(32'h7FFF_0000, 16'd0, 1'b0, 1'b0);
    drain();
    check16("pos_sat_data", out_data, 16'h7FFF);
    check16("pos_sat_cnt", sat_cnt, 16'd1);
    bias_mem[0] = 16'h8000;
    send(32'h8000_0000, 16'd0, 1'b0, 1'b0);
    drain();
    check16("neg_sat_data", out_data, 16'h8000);
    check16("neg_sat_cnt", sat_cnt, 16'd2);
  endtask

  task automatic test_relu();
    bias_mem[1] = 16'd0;
    send(32'hFFFF_FF00, 16'd1, 1'b0, 1'b1);
    drain();
    check16("relu_on", out_data, 16'h0000);
    send(32'hFFFF_FF00, 16'd1, 1'b0, 1'b0);
    drain();
    check16("relu_off", out_data, 16'hFFFF);
    check16("relu_sat_cnt", sat_cnt, 16'd2);
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < CH_NUM; i++) bias_mem[i] = 16'($urandom());
    rdy_mode = 1;
    for (int c = 0; c < CH_NUM; c++)
      send(32'($signed(24'($urandom()))), 16'(c), c == CH_NUM - 1, 1'($urandom_range(0, 1)));
    drain();
    rdy_mode = 0;
    check16("bp_last_ch", out_ch, 16'd9);
    check16("bp_last_flag", {15'd0, out_last}, 16'd1);
  endtask

  task automatic test_full_stall();
    rdy_mode = 3;
    @(posedge clk);
    #1;
    send(32'h0000_0100, 16'd2, 1'b0, 1'b0);
    send(32'h0000_0200, 16'd4, 1'b0, 1'b0);
    in_valid = 1; in_acc = 32'h0000_0300; in_ch = 16'd6; in_last = 1; relu_en = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check16("full_in_ready", {15'd0, in_ready}, 16'd0);
    end
    rdy_mode = 0;
    send(32'h0000_0300, 16'd6, 1'b1, 1'b0);
    drain();
  endtask

  task automatic test_bad_channel();
    send(32'h0001_2300, 16'd12, 1'b0, 1'b0);
    drain();
    check16("bad_ch_data", out_data, 16'h0123);
    check16("bad_ch_err", {15'd0, err_ch}, 16'd1);
    send(32'h0000_0500, 16'd2, 1'b0, 1'b0);
    send(32'h0000_0700, 16'd5, 1'b1, 1'b1);
    drain();
    check16("err_sticky", {15'd0, err_ch}, 16'd1);
  endtask

  task automatic test_random();
    logic [31:0] acc;
    rdy_mode = 2;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 2))
        0: acc = $urandom();
        1: acc = 32'($signed(24'($urandom())));
        default: acc = 32'($signed(16'($urandom())));
      endcase
      send(acc, 16'($urandom_range(0, 11)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    drain();
    rdy_mode = 0;
    check16("rand_sat_cnt", sat_cnt, sat_exp);
    check16("rand_err_ch", {15'd0, err_ch}, {15'd0, err_exp});
  endtask

  task automatic test_reset_mid();
    rdy_mode = 3;
    @(posedge clk);
    #1;
    send(32'h0000_1000, 16'd1, 1'b0, 1'b0);
    send(32'h0000_2000, 16'd2, 1'b1, 1'b0);
    #1;
    rst = 0;
    #1;
    check16("async_reset_valid", {15'd0, out_valid}, 16'd0);
    exp_q.delete();
    sat_exp = 0;
    err_exp = 0;
    @(posedge clk);
    #1;
    rst = 1;
    rdy_mode = 0;
    @(negedge clk);
    check16("post_reset_in_ready", {15'd0, in_ready}, 16'd1);
    check16("post_reset_sat_cnt", sat_cnt, 16'd0);
    check16("post_reset_err_ch", {15'd0, err_ch}, 16'd0);
    repeat (5) @(negedge clk);
    check16("no_stale_output", {15'd0, out_valid}, 16'd0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_relu();
    test_backpressure();
    test_full_stall();
    test_bad_channel();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
